// File: rtl/dfe_apb_pkg.sv
// -----------------------------------------------------------------------------
// dfe_apb_pkg
// Shared definitions for the APB coefficient bank:
//   apb_state_e   bridge FSM states (IDLE/SETUP/ACCESS/DONE)
//   reg_kind_e    decoded register class of a per-bank word address
//   CNT_WIDTH     width of the per-bank commit counter
//   commit_ofs / status_ofs   register offsets derived from the bank depth
//   decode_reg    address -> register class
//   status_word   STATUS register layout {commit_cnt[15:8], dirty[0]}
// -----------------------------------------------------------------------------
package dfe_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE
   } apb_state_e;

   typedef enum logic [1:0] {
      REG_SLOT,
      REG_COMMIT,
      REG_STATUS,
      REG_NONE
   } reg_kind_e;

   localparam int CNT_WIDTH = 8;

   // The control registers sit directly above the coefficient slots.
   function automatic int commit_ofs(input int depth);
      return depth;
   endfunction

   function automatic int status_ofs(input int depth);
      return depth + 1;
   endfunction

   function automatic reg_kind_e decode_reg(input int addr, input int depth);
      if (addr < depth)                   return REG_SLOT;
      else if (addr == commit_ofs(depth)) return REG_COMMIT;
      else if (addr == status_ofs(depth)) return REG_STATUS;
      else                                return REG_NONE;
   endfunction

   function automatic logic [15:0] status_word(input logic [CNT_WIDTH-1:0] cnt,
                                               input logic                 dirty);
      return {cnt, 7'b0, dirty};
   endfunction

endpackage

// File: rtl/coeff_bank_slot.sv
// -----------------------------------------------------------------------------
// coeff_bank_slot
// One double-buffered coefficient bank: shadow storage written by the bus,
// active storage copied from shadow in a single cycle on commit.
// Configuration macro: COEFF_READBACK_EN -- when defined, rdata returns the
// addressed shadow word; otherwise rdata is tied to 0 and no read mux exists.
// Ports:
//   clk, rst     clock, async active-high reset
//   wr_en        store wdata into shadow[idx], set dirty
//   commit_en    copy shadow->active, clear dirty, bump commit_cnt
//   idx          slot index
//   wdata        coefficient to store
//   rdata        shadow[idx] (readback builds only)
//   active       active coefficients
//   dirty        shadow differs from active since last commit
//   commit_cnt   wrapping commit counter
//   vld          one-cycle pulse the cycle after a commit
// -----------------------------------------------------------------------------
module coeff_bank_slot
   import dfe_apb_pkg::*;
#(
   parameter int COEFF_WIDTH = 20,
   parameter int DEPTH       = 72,
   parameter int IDX_WIDTH   = $clog2(DEPTH)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_en,
   input  logic                              commit_en,
   input  logic [IDX_WIDTH-1:0]              idx,
   input  logic [COEFF_WIDTH-1:0]            wdata,
   output logic [COEFF_WIDTH-1:0]            rdata,
   output logic [DEPTH-1:0][COEFF_WIDTH-1:0] active,
   output logic                              dirty,
   output logic [CNT_WIDTH-1:0]              commit_cnt,
   output logic                              vld
);

   logic [DEPTH-1:0][COEFF_WIDTH-1:0] shadow;

   // NOTE: both arrays are reset because the active outputs must read 0 out of
   // reset; that makes them flops rather than RAM, which the bank size allows.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow     <= '0;
         active     <= '0;
         dirty      <= 1'b0;
         commit_cnt <= '0;
         vld        <= 1'b0;
      end else begin
         vld <= commit_en;
         // wr_en and commit_en are never high together: one transfer in flight.
         if (wr_en) begin
            shadow[idx] <= wdata;
            dirty       <= 1'b1;
         end
         if (commit_en) begin
            active     <= shadow;
            dirty      <= 1'b0;
            commit_cnt <= commit_cnt + 1'b1;
         end
      end
   end

`ifdef COEFF_READBACK_EN
   assign rdata = shadow[idx];
`else
   assign rdata = '0;
`endif

endmodule

// File: rtl/apb_coeff_bank.sv
// -----------------------------------------------------------------------------
// apb_coeff_bank
// Master request port -> internal APB bridge FSM -> NUM_COMP double-buffered
// coefficient banks. Each transfer walks IDLE->SETUP->ACCESS->DONE; ACCESS
// holds for WAIT_STATES cycles of PREADY=0 before the bank access completes.
// Configuration macro: COEFF_READBACK_EN (applied inside coeff_bank_slot):
// slot reads return the sign-extended shadow word when defined, 0 otherwise.
// Ports:
//   clk, rst      clock, async active-high reset
//   m_trans       request strobe, sampled only while idle
//   m_write       1 = write, 0 = read
//   m_sel         one-hot component select
//   m_addr        word address inside the component
//   m_wdata       write data
//   m_busy        transfer in flight (SETUP/ACCESS/DONE)
//   m_done        one-cycle completion pulse
//   m_err         error flag, valid with m_done
//   m_rdata       read data, valid with m_done; 0 on write or error
//   coeff_out     active coefficients per component and slot
//   coeff_vld     per-bank pulse the cycle after its commit
// Register map per bank: 0..DEPTH-1 slots (RW), DEPTH commit (WO),
// DEPTH+1 status (RO), anything above is an error.
// -----------------------------------------------------------------------------
module apb_coeff_bank
   import dfe_apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 7,
   parameter int PDATA_WIDTH = 32,
   parameter int COEFF_WIDTH = 20,
   parameter int NUM_COMP    = 5,
   parameter int DEPTH       = 72,
   parameter int WAIT_STATES = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          m_trans,
   input  logic                          m_write,
   input  logic [NUM_COMP-1:0]           m_sel,
   input  logic [ADDR_WIDTH-1:0]         m_addr,
   input  logic [PDATA_WIDTH-1:0]        m_wdata,
   output logic                          m_busy,
   output logic                          m_done,
   output logic                          m_err,
   output logic [PDATA_WIDTH-1:0]        m_rdata,
   output logic signed [COEFF_WIDTH-1:0] coeff_out [NUM_COMP][DEPTH],
   output logic [NUM_COMP-1:0]           coeff_vld
);

   localparam int IDX_WIDTH = $clog2(DEPTH);

   // Latched request
   apb_state_e               state;
   logic                     req_write;
   logic [NUM_COMP-1:0]      req_sel;
   logic [ADDR_WIDTH-1:0]    req_addr;
   logic [PDATA_WIDTH-1:0]   req_wdata;
   logic [3:0]               wait_cnt;

   // Slave side
   logic                     pready;
   reg_kind_e                reg_kind;
   logic                     acc_err;
   logic [PDATA_WIDTH-1:0]   acc_rdata;
   logic [NUM_COMP-1:0]      slot_wr;
   logic [NUM_COMP-1:0]      slot_commit;
   logic [COEFF_WIDTH-1:0]   sel_coeff;
   logic [15:0]              sel_status;

   // Bank outputs
   logic [COEFF_WIDTH-1:0]            slot_rdata  [NUM_COMP];
   logic [DEPTH-1:0][COEFF_WIDTH-1:0] slot_active [NUM_COMP];
   logic [NUM_COMP-1:0]               slot_dirty;
   logic [CNT_WIDTH-1:0]              slot_cnt    [NUM_COMP];

   // Upper write-data bits only matter for commit/status decode of bit 0.
   logic unused_wdata;
   assign unused_wdata = ^req_wdata;

   // PSEL is implied by SETUP/ACCESS, PENABLE by ACCESS; the slave completes
   // once the wait-state counter reaches WAIT_STATES.
   assign pready   = (state == ST_ACCESS) && (wait_cnt == 4'(WAIT_STATES));
   assign reg_kind = decode_reg(int'(req_addr), DEPTH);

   // Only the selected bank contributes; req_sel is one-hot whenever a bank
   // access is reached.
   // NOTE: every combinational output gets a default before the loop/case so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_coeff  = '0;
      sel_status = '0;
      for (int g = 0; g < NUM_COMP; g++) begin
         if (req_sel[g]) begin
            sel_coeff  = sel_coeff | slot_rdata[g];
            sel_status = sel_status | status_word(slot_cnt[g], slot_dirty[g]);
         end
      end
   end

   always_comb begin
      acc_err     = 1'b0;
      acc_rdata   = '0;
      slot_wr     = '0;
      slot_commit = '0;
      case (reg_kind)
         REG_SLOT: begin
            if (req_write) begin
               if (pready) slot_wr = req_sel;
            end else begin
               acc_rdata = PDATA_WIDTH'($signed(sel_coeff));
            end
         end
         REG_COMMIT: begin
            if (!req_write)          acc_err     = 1'b1;
            else if (req_wdata[0] && pready) slot_commit = req_sel;
         end
         REG_STATUS: begin
            if (req_write) acc_err   = 1'b1;
            else           acc_rdata = PDATA_WIDTH'(sel_status);
         end
         default: acc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         req_write <= 1'b0;
         req_sel   <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         wait_cnt  <= '0;
         m_busy    <= 1'b0;
         m_done    <= 1'b0;
         m_err     <= 1'b0;
         m_rdata   <= '0;
      end else begin
         m_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (m_trans) begin
                  req_write <= m_write;
                  req_sel   <= m_sel;
                  req_addr  <= m_addr;
                  req_wdata <= m_wdata;
                  m_busy    <= 1'b1;
                  if ($onehot(m_sel)) begin
                     state <= ST_SETUP;
                  end else begin
                     // Bad select never reaches a bank.
                     state   <= ST_DONE;
                     m_done  <= 1'b1;
                     m_err   <= 1'b1;
                     m_rdata <= '0;
                  end
               end
            end
            ST_SETUP: begin
               state    <= ST_ACCESS;
               wait_cnt <= '0;
            end
            ST_ACCESS: begin
               if (pready) begin
                  state   <= ST_DONE;
                  m_done  <= 1'b1;
                  m_err   <= acc_err;
                  m_rdata <= acc_rdata;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               m_busy  <= 1'b0;
               m_err   <= 1'b0;
               m_rdata <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_COMP; g++) begin : g_bank
      coeff_bank_slot #(
         .COEFF_WIDTH (COEFF_WIDTH),
         .DEPTH       (DEPTH),
         .IDX_WIDTH   (IDX_WIDTH)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .wr_en      (slot_wr[g]),
         .commit_en  (slot_commit[g]),
         .idx        (req_addr[IDX_WIDTH-1:0]),
         .wdata      (req_wdata[COEFF_WIDTH-1:0]),
         .rdata      (slot_rdata[g]),
         .active     (slot_active[g]),
         .dirty      (slot_dirty[g]),
         .commit_cnt (slot_cnt[g]),
         .vld        (coeff_vld[g])
      );
   end

   always_comb begin
      for (int g = 0; g < NUM_COMP; g++) begin
         for (int j = 0; j < DEPTH; j++) begin
            coeff_out[g][j] = slot_active[g][j];
         end
      end
   end

endmodule

// File: tb/tb_apb_coeff_bank.sv
// -----------------------------------------------------------------------------
// tb_apb_coeff_bank
// Directed plus randomized transfers against a register-level reference
// model of the coefficient banks (arrays of shadow/active words, dirty flags
// and commit counters). Runs with WAIT_STATES=3.
// -----------------------------------------------------------------------------
module tb_apb_coeff_bank;

   localparam int AW    = 7;
   localparam int PW    = 32;
   localparam int CW    = 20;
   localparam int NC    = 5;
   localparam int DEPTH = 72;
   localparam int WS    = 3;

`ifdef COEFF_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 m_trans;
   logic                 m_write;
   logic [NC-1:0]        m_sel;
   logic [AW-1:0]        m_addr;
   logic [PW-1:0]        m_wdata;
   logic                 m_busy;
   logic                 m_done;
   logic                 m_err;
   logic [PW-1:0]        m_rdata;
   logic signed [CW-1:0] coeff_out [NC][DEPTH];
   logic [NC-1:0]        coeff_vld;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model
   logic [CW-1:0] shadow_m [NC][DEPTH];
   logic [CW-1:0] active_m [NC][DEPTH];
   bit            dirty_m  [NC];
   int            cnt_m    [NC];
   int            vld_exp  [NC];
   int            vld_seen [NC];
   int            done_seen;

   always #5 clk = ~clk;

   apb_coeff_bank #(
      .ADDR_WIDTH  (AW),
      .PDATA_WIDTH (PW),
      .COEFF_WIDTH (CW),
      .NUM_COMP    (NC),
      .DEPTH       (DEPTH),
      .WAIT_STATES (WS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_trans   (m_trans),
      .m_write   (m_write),
      .m_sel     (m_sel),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_busy    (m_busy),
      .m_done    (m_done),
      .m_err     (m_err),
      .m_rdata   (m_rdata),
      .coeff_out (coeff_out),
      .coeff_vld (coeff_vld)
   );

   always @(negedge clk) begin
      for (int g = 0; g < NC; g++) if (coeff_vld[g]) vld_seen[g]++;
      if (m_done) done_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sext(input logic [CW-1:0] v);
      logic [31:0] w;
      w = 32'(v);
      if (v >= (CW)'(1 << (CW - 1))) w = w - (32'd1 << CW);
      return w;
   endfunction

   task automatic model_reset();
      for (int g = 0; g < NC; g++) begin
         for (int j = 0; j < DEPTH; j++) begin
            shadow_m[g][j] = '0;
            active_m[g][j] = '0;
         end
         dirty_m[g] = 1'b0;
         cnt_m[g]   = 0;
      end
   endtask

   task automatic check_banks(input string tag);
      int bad;
      int vbad;
      bad  = 0;
      vbad = 0;
      for (int g = 0; g < NC; g++) begin
         for (int j = 0; j < DEPTH; j++) if (coeff_out[g][j] !== active_m[g][j]) bad++;
         if (vld_seen[g] != vld_exp[g]) vbad++;
      end
      check({tag, ":coeff_out"}, bad, 0);
      check({tag, ":vld_cnt"}, vbad, 0);
   endtask

   // One complete transfer: update model, drive request, wait for m_done,
   // check latency/err/rdata, then check the idle cycle and all banks.
   task automatic xfer(input logic wr, input logic [NC-1:0] sel, input int addr,
                       input logic [31:0] wd, input bit hold, input string tag);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          lat;
      int          c;
      bit          seen;
      exp_rd  = '0;
      exp_err = 1'b0;
      if ($countones(sel) != 1) begin
         exp_err = 1'b1;
         exp_lat = 1;
      end else begin
         c       = $clog2(sel);
         exp_lat = 3 + WS;
         if (addr < DEPTH) begin
            if (wr) begin
               shadow_m[c][addr] = wd[CW-1:0];
               dirty_m[c]        = 1'b1;
            end else begin
               exp_rd = READBACK ? sext(shadow_m[c][addr]) : 32'd0;
            end
         end else if (addr == DEPTH) begin
            if (!wr) exp_err = 1'b1;
            else if (wd[0]) begin
               for (int j = 0; j < DEPTH; j++) active_m[c][j] = shadow_m[c][j];
               dirty_m[c] = 1'b0;
               cnt_m[c]   = (cnt_m[c] + 1) % 256;
               vld_exp[c]++;
            end
         end else if (addr == DEPTH + 1) begin
            if (wr) exp_err = 1'b1;
            else    exp_rd  = 32'(cnt_m[c] * 256 + int'(dirty_m[c]));
         end else begin
            exp_err = 1'b1;
         end
      end

      @(negedge clk);
      m_trans = 1'b1;
      m_write = wr;
      m_sel   = sel;
      m_addr  = AW'(addr);
      m_wdata = wd;
      lat     = 0;
      seen    = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!hold) m_trans = 1'b0;
         if (lat == 1) check({tag, ":busy"}, m_busy, 1);
         if (m_done) seen = 1'b1;
      end
      m_trans = 1'b0;
      check({tag, ":done"}, seen, 1);
      check({tag, ":latency"}, lat, exp_lat);
      check({tag, ":err"}, m_err, exp_err);
      check({tag, ":rdata"}, m_rdata, exp_rd);

      @(negedge clk);
      check({tag, ":done_pulse"}, m_done, 0);
      check({tag, ":busy_clr"}, m_busy, 0);
      check({tag, ":vld_pulse"}, coeff_vld, 0);
      #1;
      check_banks(tag);
   endtask

   initial begin
      int d0;
      int r;
      logic [NC-1:0] sel;
      int addr;
      logic [31:0] wd;

      rst     = 1'b1;
      m_trans = 1'b0;
      m_write = 1'b0;
      m_sel   = '0;
      m_addr  = '0;
      m_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);

      // Reset state
      check("rst:busy", m_busy, 0);
      check("rst:done", m_done, 0);
      check("rst:err", m_err, 0);
      check("rst:rdata", m_rdata, 0);
      check("rst:vld", coeff_vld, 0);
      check_banks("rst");
      rst = 1'b0;

      // Slot write with m_trans held through busy: must complete once only.
      xfer(1'b1, 5'b00001, 5, 32'h000F_FFFF, 1'b1, "wr_b0a5_hold");
      d0 = done_seen;
      repeat (10) @(negedge clk);
      #1;
      check("busy_ignore:extra_done", done_seen - d0, 0);
      xfer(1'b0, 5'b00001, DEPTH + 1, 32'h0, 1'b0, "status_dirty");
      xfer(1'b0, 5'b00001, 5, 32'h0, 1'b0, "rd_b0a5");

      // Commit bank 0
      xfer(1'b1, 5'b00001, DEPTH, 32'h1, 1'b0, "commit_b0");
      check("coeff_b0a5", {12'h0, coeff_out[0][5]}, 32'h000F_FFFF);
      check("vld_b0_once", vld_seen[0], 1);
      xfer(1'b0, 5'b00001, DEPTH + 1, 32'h0, 1'b0, "status_0x100");
      check("status_0x100:value", m_rdata, 32'h0); // m_rdata cleared after DONE

      // Negative coefficient, commit with bit0=0 ignored
      xfer(1'b1, 5'b00001, 6, 32'h0008_0000, 1'b0, "wr_b0a6_neg");
      xfer(1'b0, 5'b00001, 6, 32'h0, 1'b0, "rd_b0a6_sext");
      xfer(1'b1, 5'b00001, DEPTH, 32'hFFFF_FFFE, 1'b0, "commit_b0_bit0_0");
      xfer(1'b0, 5'b00001, DEPTH + 1, 32'h0, 1'b0, "status_0x101");

      // Error cases
      xfer(1'b1, 5'b00011, 5, 32'h1234, 1'b0, "bad_sel_wr");
      xfer(1'b0, 5'b00000, 5, 32'h0, 1'b0, "bad_sel_zero");
      xfer(1'b1, 5'b00010, DEPTH + 2, 32'h1, 1'b0, "bad_addr_wr");
      xfer(1'b0, 5'b00010, DEPTH + 2, 32'h0, 1'b0, "bad_addr_rd");
      xfer(1'b0, 5'b00010, DEPTH, 32'h0, 1'b0, "commit_rd");
      xfer(1'b1, 5'b00010, DEPTH + 1, 32'h1, 1'b0, "status_wr");

      // 256 commits on bank 2: counter wraps to 0
      xfer(1'b1, 5'b00100, 0, 32'h0001_2345, 1'b0, "wr_b2a0");
      for (int i = 0; i < 256; i++) xfer(1'b1, 5'b00100, DEPTH, 32'h1, 1'b0, "commit_b2");
      check("commit_b2:vld_total", vld_seen[2], 256);
      xfer(1'b0, 5'b00100, DEPTH + 1, 32'h0, 1'b0, "status_b2_wrap");

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         r   = $urandom_range(0, 9);
         sel = (r == 0) ? NC'($urandom) : (NC'(1) << $urandom_range(0, NC - 1));
         r   = $urandom_range(0, 9);
         if (r < 5)       addr = $urandom_range(0, DEPTH - 1);
         else if (r < 7)  addr = DEPTH;
         else if (r == 7) addr = DEPTH + 1;
         else             addr = $urandom_range(DEPTH + 2, (1 << AW) - 1);
         wd = $urandom;
         xfer(1'($urandom_range(0, 1)), sel, addr, wd, 1'b0, "rand");
      end

      // Reset during ACCESS aborts the transfer
      @(negedge clk);
      m_trans = 1'b1;
      m_write = 1'b1;
      m_sel   = 5'b00010;
      m_addr  = AW'(3);
      m_wdata = 32'h0005_5555;
      @(negedge clk);
      m_trans = 1'b0;
      @(negedge clk);
      @(negedge clk);
      d0  = done_seen;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_access:busy", m_busy, 0);
      check("rst_access:done", m_done, 0);
      check("rst_access:err", m_err, 0);
      check("rst_access:rdata", m_rdata, 0);
      check_banks("rst_access");
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("rst_access:no_done", done_seen - d0, 0);
      xfer(1'b0, 5'b00010, DEPTH + 1, 32'h0, 1'b0, "rst_access:status");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
